hex_step_counter: RTL and testbench

//  Produces the 4-bit hex value consumed by the 7-segment decoder stage; sits directly upstream of it.

---
 rtl/hex_step_counter_pkg.sv | 25 ++
 rtl/hex_step_counter_btn_debounce.sv | 43 ++++
 rtl/hex_step_counter.sv | 65 ++++++
 tb/tb_hex_step_counter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/hex_step_counter_pkg.sv
// Shared constants for the hex counter and the 7-segment decoder stage.
// Widths, wrap value and default timing parameters live here.
package hex_step_counter_pkg;

  localparam int HEX_W = 4;
  localparam logic [HEX_W-1:0] HEX_MAX = 4'hF;

  localparam int DEF_PRESCALE_DIV = 12_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 120_000;

  function automatic logic [HEX_W-1:0] hex_next(
    input logic [HEX_W-1:0] cur,
    input logic up
  );
    return up ? cur + 1'b1 : cur - 1'b1;
  endfunction

  function automatic logic hex_wraps(
    input logic [HEX_W-1:0] cur,
    input logic up
  );
    return up ? (cur == HEX_MAX) : (cur == '0);
  endfunction

endpackage

// File: rtl/hex_step_counter_btn_debounce.sv
// Pushbutton front end: 2-FF synchroniser, stability counter and
// a one-cycle press pulse on each accepted release->press change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 120_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic level,
  output logic press_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      level       <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= raw_n;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        // this sample is the last of the required stable run
        level       <= sync2;
        cnt         <= '0;
        press_pulse <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_step_counter.sv
// Hex value source for the 7-segment decoder: prescaled auto-count
// or debounced button stepping, with tick and wrap strobes.
module hex_step_counter
  import hex_step_counter_pkg::*;
#(
  parameter int PRESCALE_DIV = DEF_PRESCALE_DIV,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_n,
  input  logic             run,
  input  logic             dir,
  output logic [HEX_W-1:0] hex_out,
  output logic             tick_out,
  output logic             wrap_out
);

  localparam int PW = $clog2(PRESCALE_DIV);

  logic [PW-1:0] pcnt;
  logic          pre_tick;
  logic          btn_level;
  logic          btn_press;
  logic          step_req;
  logic          advance;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk        (clk),
    .rst        (rst),
    .raw_n      (btn_n),
    .level      (btn_level),
    .press_pulse(btn_press)
  );

  // a press pulse always coincides with the level going low
  assign step_req = btn_press & ~btn_level;
  assign pre_tick = run && (pcnt == PW'(PRESCALE_DIV - 1));
  assign advance  = pre_tick | step_req;

  always_ff @(posedge clk) begin
    if (rst || !run || pre_tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hex_out  <= '0;
      tick_out <= 1'b0;
      wrap_out <= 1'b0;
    end else begin
      tick_out <= advance;
      wrap_out <= advance & hex_wraps(hex_out, dir);
      if (advance) begin
        hex_out <= hex_next(hex_out, dir);
      end
    end
  end

endmodule

// File: tb/tb_hex_step_counter.sv
// Directed bench for hex_step_counter with a short prescale and debounce.
module tb_hex_step_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_n;
  logic       run;
  logic       dir;
  logic [3:0] hex_out;
  logic       tick_out;
  logic       wrap_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hex_step_counter #(
    .PRESCALE_DIV   (4),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_n   (btn_n),
    .run     (run),
    .dir     (dir),
    .hex_out (hex_out),
    .tick_out(tick_out),
    .wrap_out(wrap_out)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // three quiet cycles then a step, assuming prescaler phase is 0
  task automatic period(input logic [3:0] h, input logic w);
    repeat (3) begin
      cyc();
      chk("idle_tick", {3'b0, tick_out}, 4'd0);
    end
    cyc();
    chk("step_hex", hex_out, h);
    chk("step_tick", {3'b0, tick_out}, 4'd1);
    chk("step_wrap", {3'b0, wrap_out}, {3'b0, w});
  endtask

  initial begin
    rst   = 1'b1;
    run   = 1'b1;
    dir   = 1'b1;
    btn_n = 1'b1;

    // reset and auto-count
    cyc();
    chk("rst_hex", hex_out, 4'd0);
    chk("rst_tick", {3'b0, tick_out}, 4'd0);
    chk("rst_wrap", {3'b0, wrap_out}, 4'd0);
    cyc();
    chk("rst_hex2", hex_out, 4'd0);
    rst = 1'b0;
    for (int v = 1; v <= 14; v++) period(4'(v), 1'b0);

    // wrap up then down
    period(4'hF, 1'b0);
    period(4'h0, 1'b1);
    period(4'h1, 1'b0);
    dir = 1'b0;
    period(4'h0, 1'b0);
    period(4'hF, 1'b1);

    // debounce: short glitch rejected
    run   = 1'b0;
    btn_n = 1'b0;
    cyc();
    cyc();
    btn_n = 1'b1;
    repeat (10) begin
      cyc();
      chk("glitch_tick", {3'b0, tick_out}, 4'd0);
    end
    chk("glitch_hex", hex_out, 4'hF);

    // debounce: held press gives one step
    btn_n = 1'b0;
    repeat (5) begin
      cyc();
      chk("press_wait", {3'b0, tick_out}, 4'd0);
    end
    cyc();
    chk("press_tick", {3'b0, tick_out}, 4'd1);
    chk("press_hex", hex_out, 4'hE);
    chk("press_wrap", {3'b0, wrap_out}, 4'd0);
    repeat (4) begin
      cyc();
      chk("press_hold", {3'b0, tick_out}, 4'd0);
    end
    btn_n = 1'b1;
    repeat (10) begin
      cyc();
      chk("release_tick", {3'b0, tick_out}, 4'd0);
    end
    chk("release_hex", hex_out, 4'hE);

    // collision: press pulse lands on the pre_tick cycle
    dir   = 1'b1;
    btn_n = 1'b0;
    cyc();
    cyc();
    run = 1'b1;
    repeat (3) begin
      cyc();
      chk("coll_wait", {3'b0, tick_out}, 4'd0);
    end
    cyc();
    chk("coll_hex", hex_out, 4'hF);
    chk("coll_tick", {3'b0, tick_out}, 4'd1);
    period(4'h0, 1'b1);
    btn_n = 1'b1;

    // run gating
    run = 1'b0;
    repeat (20) begin
      cyc();
      chk("hold_hex", hex_out, 4'h0);
      chk("hold_tick", {3'b0, tick_out}, 4'd0);
    end
    run = 1'b1;
    period(4'h1, 1'b0);

    // reset mid-operation at 9 with a press being debounced
    for (int v = 2; v <= 9; v++) period(4'(v), 1'b0);
    btn_n = 1'b0;
    repeat (3) cyc();
    rst   = 1'b1;
    btn_n = 1'b1;
    cyc();
    chk("mid_rst_hex", hex_out, 4'h0);
    chk("mid_rst_tick", {3'b0, tick_out}, 4'd0);
    chk("mid_rst_wrap", {3'b0, wrap_out}, 4'd0);
    rst = 1'b0;
    period(4'h1, 1'b0);
    period(4'h2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
